// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB op encodings, sizes and sequencer state codes.
// Imported by tlb_op_ctrl and tlb_random_ctr.
package tlb_op_ctrl_pkg;

  localparam int TLB_LINE_DEF  = 32;
  localparam int TLB_WIDTH_DEF = 5;

  typedef logic [2:0] tlb_op_t;

  localparam tlb_op_t TLB_NONE = 3'd0;
  localparam tlb_op_t TLBP     = 3'd1;
  localparam tlb_op_t TLBR     = 3'd2;
  localparam tlb_op_t TLBWI    = 3'd3;
  localparam tlb_op_t TLBWR    = 3'd4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_RESP  = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  function automatic logic is_write(tlb_op_t op);
    return (op == TLBWI) || (op == TLBWR);
  endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random counter: counts down from TLB_LINE-1 to Wired.
// Ports: run_i (count enable), wired_i/wired_we_i, rnd_o.
module tlb_random_ctr
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_LINE  = TLB_LINE_DEF,
  parameter int TLB_WIDTH = TLB_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic [TLB_WIDTH-1:0] wired_i,
  input  logic                 wired_we_i,
  output logic [TLB_WIDTH-1:0] rnd_o
);

  localparam logic [TLB_WIDTH-1:0] MAX =
    TLB_WIDTH'(TLB_LINE - 1);

  logic [TLB_WIDTH-1:0] rnd_q;
  logic [TLB_WIDTH-1:0] rnd_d;
  logic                 wrap;

  // Wrap back to the top once Wired (or zero) is reached;
  // a Wired at or above the top pins the counter there.
  assign wrap = (wired_i >= MAX)
              | (rnd_q == wired_i)
              | (rnd_q == '0);

  always_comb begin
    rnd_d = rnd_q;
    if (wired_we_i) begin
      rnd_d = MAX;
    end else if (run_i) begin
      rnd_d = wrap ? MAX : rnd_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q <= MAX;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign rnd_o = rnd_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR from the M stage.
// Ports: op in, stall/done/refetch out, tlb_type, CP0 strobes.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_LINE  = TLB_LINE_DEF,
  parameter int TLB_WIDTH = TLB_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic [2:0]           op_type,
  input  logic                 flush,
  input  logic [31:0]          index_in,
  input  logic [TLB_WIDTH-1:0] wired_in,
  input  logic                 wired_we,
  input  logic                 probe_hit,
  input  logic [TLB_WIDTH-1:0] probe_idx,
  output logic                 stall,
  output logic                 done,
  output logic                 refetch,
  output logic [2:0]           tlb_type,
  output logic [31:0]          random_out,
  output logic                 index_we,
  output logic [31:0]          index_wdata,
  output logic                 entry_we
);

  state_t               state_q, state_d;
  tlb_op_t              op_q, op_d;
  logic                 hit_q, hit_d;
  logic [TLB_WIDTH-1:0] pidx_q, pidx_d;
  logic                 sup_q, sup_d;

  logic                 in_idle, in_issue;
  logic                 in_resp, in_done;
  logic                 accept, sup;
  logic [TLB_WIDTH-1:0] rnd;
  logic                 unused_idx;

  assign unused_idx = ^{index_in[30:6], index_in[4:0]};

  assign in_idle  = (state_q == S_IDLE);
  assign in_issue = (state_q == S_ISSUE);
  assign in_resp  = (state_q == S_RESP);
  assign in_done  = (state_q == S_DONE);

  assign accept = in_idle & op_valid
                & (op_type != TLB_NONE) & ~flush;

  // P or out-of-range blocks writes; out-of-range blocks reads.
  assign sup = (is_write(op_q)
               & (index_in[31] | index_in[5]))
             | ((op_q == TLBR) & index_in[5]);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hit_d   = hit_q;
    pidx_d  = pidx_q;
    sup_d   = sup_q;
    unique case (1'b1)
      in_idle: begin
        if (accept) begin
          state_d = S_ISSUE;
          op_d    = op_type;
        end
      end
      in_issue: begin
        state_d = S_RESP;
        hit_d   = probe_hit;
        pidx_d  = probe_idx;
        sup_d   = sup;
      end
      in_resp: state_d = S_DONE;
      in_done: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= TLB_NONE;
      hit_q   <= 1'b0;
      pidx_q  <= '0;
      sup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hit_q   <= hit_d;
      pidx_q  <= pidx_d;
      sup_q   <= sup_d;
    end
  end

  // Random freezes from the accept cycle so TLBWR
  // uses the value seen when the op was taken.
  tlb_random_ctr #(
    .TLB_LINE  (TLB_LINE),
    .TLB_WIDTH (TLB_WIDTH)
  ) u_rnd (
    .clk        (clk),
    .rst        (rst),
    .run_i      (in_idle & ~accept),
    .wired_i    (wired_in),
    .wired_we_i (wired_we),
    .rnd_o      (rnd)
  );

  assign random_out = {{(32-TLB_WIDTH){1'b0}}, rnd};

  assign stall    = accept | in_issue | in_resp;
  assign done     = in_done;
  assign refetch  = in_done & is_write(op_q);
  assign tlb_type = (in_issue & ~sup) ? op_q : TLB_NONE;
  assign index_we = in_resp & (op_q == TLBP);
  assign entry_we = in_resp & (op_q == TLBR) & ~sup_q;

  always_comb begin
    index_wdata = '0;
    if (index_we) begin
      index_wdata = hit_q
        ? {{(32-TLB_WIDTH){1'b0}}, pidx_q}
        : 32'h8000_0000;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl with random ops.
// Reference: per-op output table plus a Random model.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_type;
  logic        flush;
  logic [31:0] index_in;
  logic [4:0]  wired_in;
  logic        wired_we;
  logic        probe_hit;
  logic [4:0]  probe_idx;
  logic        stall, done, refetch;
  logic [2:0]  tlb_type;
  logic [31:0] random_out;
  logic        index_we;
  logic [31:0] index_wdata;
  logic        entry_we;

  tlb_op_ctrl #(
    .TLB_LINE  (32),
    .TLB_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_type     (op_type),
    .flush       (flush),
    .index_in    (index_in),
    .wired_in    (wired_in),
    .wired_we    (wired_we),
    .probe_hit   (probe_hit),
    .probe_idx   (probe_idx),
    .stall       (stall),
    .done        (done),
    .refetch     (refetch),
    .tlb_type    (tlb_type),
    .random_out  (random_out),
    .index_we    (index_we),
    .index_wdata (index_wdata),
    .entry_we    (entry_we)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic [2:0]  tt;
    logic        iwe;
    logic [31:0] wd;
    logic        ewe;
    logic        done;
    logic        rf;
  } ov_t;

  ov_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  m      = 31;
  int  frz    = 0;
  bit  run    = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Random register model: counts down while idle,
  // frozen for the four cycles of an accepted op.
  always @(posedge clk or posedge rst) begin
    bit busy;
    if (rst) begin
      m = 31;
    end else begin
      busy = (frz > 0);
      if (busy) frz--;
      if (wired_we) m = 31;
      else if (!busy) begin
        if (wired_in >= 31 || m == int'(wired_in)
            || m == 0) m = 31;
        else m = m - 1;
      end
    end
  end

  // Expected outputs in cycle k (0..3) of an op.
  function automatic ov_t exp_vec(tlb_op_t op,
      logic hit, logic [4:0] pidx,
      logic [31:0] idx, int k);
    ov_t v;
    bit  wr, sp;
    v  = '0;
    wr = (op == TLBWI) || (op == TLBWR);
    sp = (wr && (idx[31] || idx[5]))
      || (op == TLBR && idx[5]);
    case (k)
      0: v.stall = 1'b1;
      1: begin
        v.stall = 1'b1;
        v.tt    = sp ? TLB_NONE : op;
      end
      2: begin
        v.stall = 1'b1;
        v.iwe   = (op == TLBP);
        if (op == TLBP)
          v.wd = hit ? {27'b0, pidx} : 32'h8000_0000;
        v.ewe   = (op == TLBR) && !idx[5];
      end
      default: begin
        v.done = 1'b1;
        v.rf   = wr;
      end
    endcase
    return v;
  endfunction

  // Monitor: every active DUT cycle consumes one entry.
  always @(negedge clk) begin
    ov_t a, e;
    bit  act;
    if (run && !rst) begin
      chk("random", random_out, 32'(m));
      a   = '{stall, tlb_type, index_we,
              index_wdata, entry_we, done, refetch};
      act = (a != '0);
      if (act) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected: got %h expected idle",
                   a);
        end else begin
          e = exp_q.pop_front();
          n_chk++;
          if (a !== e) begin
            n_fail++;
            $display("FAIL opcycle: got %h expected %h",
                     a, e);
          end
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL missing: got idle expected %h", e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(tlb_op_t op, logic hit,
      logic [4:0] pidx, logic [31:0] idx, bit fl);
    op_valid  = 1'b1;
    op_type   = op;
    probe_hit = hit;
    probe_idx = pidx;
    index_in  = idx;
    frz       = 4;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(exp_vec(op, hit, pidx, idx, k));
    tick();
    op_valid = 1'($urandom_range(0, 1));
    op_type  = 3'($urandom_range(0, 7));
    if (fl) flush = 1'b1;
    tick();
    tick();
    tick();
    flush    = 1'b0;
    op_valid = 1'b0;
    op_type  = TLB_NONE;
  endtask

  initial begin
    int  n;
    bit  ok;
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_type   = TLB_NONE;
    flush     = 1'b0;
    index_in  = '0;
    wired_in  = '0;
    wired_we  = 1'b0;
    probe_hit = 1'b0;
    probe_idx = '0;
    tick();
    tick();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_refetch", 32'(refetch), 0);
    chk("rst_tlb_type", 32'(tlb_type), 0);
    chk("rst_index_we", 32'(index_we), 0);
    chk("rst_index_wdata", index_wdata, 0);
    chk("rst_entry_we", 32'(entry_we), 0);
    chk("rst_random", random_out, 31);
    rst = 1'b0;
    run = 1;

    repeat (40) tick();

    wired_in = 5'd8;
    repeat (30) tick();
    wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    chk("wired_we_top", random_out, 31);
    repeat (30) tick();
    wired_in = 5'd0;

    do_op(TLBP, 1'b1, 5'd5, 32'h0, 1'b0);
    do_op(TLBP, 1'b0, 5'd9, 32'h0, 1'b0);

    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (m == 17) ok = 1;
      else tick();
    end
    chk("reach_rnd17", 32'(ok), 1);
    do_op(TLBWR, 1'b0, 5'd0, 32'h3, 1'b0);

    do_op(TLBWI, 1'b0, 5'd0, 32'h20, 1'b0);
    do_op(TLBWI, 1'b0, 5'd0, 32'h8000_0002, 1'b0);
    do_op(TLBR, 1'b0, 5'd0, 32'h21, 1'b0);
    do_op(TLBR, 1'b0, 5'd0, 32'h4, 1'b0);
    do_op(TLBWI, 1'b0, 5'd0, 32'h7, 1'b0);

    op_valid = 1'b1;
    op_type  = TLBP;
    flush    = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(stall), 0);
    repeat (3) tick();
    op_valid = 1'b0;
    flush    = 1'b0;
    tick();

    do_op(TLBP, 1'b1, 5'd30, 32'h0, 1'b1);
    do_op(TLBWR, 1'b0, 5'd0, 32'h0, 1'b1);

    op_valid = 1'b1;
    op_type  = TLBWI;
    index_in = 32'h2;
    frz      = 4;
    exp_q.push_back(exp_vec(TLBWI, 0, 0, 32'h2, 0));
    tick();
    op_valid = 1'b0;
    frz      = 0;
    exp_q.delete();
    rst      = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_tlb_type", 32'(tlb_type), 0);
    tick();
    chk("rst_mid_done", 32'(done), 0);
    chk("rst_mid_refetch", 32'(refetch), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 60; i++) begin
      n = $urandom_range(0, 4);
      if (n == 0) begin
        op_valid = 1'b1;
        op_type  = TLB_NONE;
        tick();
        op_valid = 1'b0;
      end else begin
        do_op(tlb_op_t'(n), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)),
              {1'($urandom_range(0, 1)), 25'd0,
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31))},
              1'($urandom_range(0, 1)));
      end
      n = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0)
        wired_in = 5'($urandom_range(0, 31));
      for (int g = 0; g < n; g++) begin
        wired_we = ($urandom_range(0, 9) == 0);
        tick();
      end
      wired_we = 1'b0;
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
